// File: rtl/segment_transition.sv
// Segment transition controller: arms a segment switch on an immediate, index-sync,
// system-time or GPIO-edge condition and counts repeats of the active segment.
module segment_transition #(
    parameter int IDX_W    = 13,
    parameter int GPIO_NUM = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [63:0]         SYS_TIME,
    input  logic                UPDATE_REQ,
    input  logic                REQ_SEGMENT,
    input  logic [2:0]          REQ_MODE,
    input  logic [63:0]         REQ_VALUE,
    input  logic [15:0]         REQ_REP,
    input  logic [GPIO_NUM-1:0] GPIO_IN,
    input  logic [IDX_W-1:0]    IDX,
    input  logic [IDX_W-1:0]    CYCLE,
    input  logic                IDX_VALID,
    output logic                SEGMENT,
    output logic                REQ_ACK,
    output logic                REQ_ERR,
    output logic                SWITCHED,
    output logic                BUSY,
    output logic                STOP
);

    localparam int GSEL_W = (GPIO_NUM > 1) ? $clog2(GPIO_NUM) : 1;

    localparam logic [2:0]  MODE_IMM  = 3'd0;
    localparam logic [2:0]  MODE_SYNC = 3'd1;
    localparam logic [2:0]  MODE_TIME = 3'd2;
    localparam logic [2:0]  MODE_GPIO = 3'd3;
    localparam logic [15:0] REP_INF   = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, WAIT_IDX, WAIT_TIME, WAIT_GPIO} state_t;

    state_t              state;
    logic                seg_lat;
    logic [63:0]         time_lat;
    logic [15:0]         rep_lat;
    logic [GSEL_W-1:0]   gsel_lat;
    logic [15:0]         rep_cnt;
    logic [GPIO_NUM-1:0] gpio_p0;
    logic [GPIO_NUM-1:0] gpio_p1;
    logic [GPIO_NUM-1:0] gpio_p2;
    logic [GPIO_NUM-1:0] gpio_rise;
    logic                req_valid;
    logic                period_end;
    logic                switch_now;

    assign req_valid  = UPDATE_REQ && (REQ_MODE <= MODE_GPIO);
    assign period_end = IDX_VALID && (IDX == CYCLE);
    assign gpio_rise  = gpio_p1 & ~gpio_p2;

    // GPIO: two synchronizer flops, then the edge-detect register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gpio_p0 <= '0;
            gpio_p1 <= '0;
            gpio_p2 <= '0;
        end else begin
            gpio_p0 <= GPIO_IN;
            gpio_p1 <= gpio_p0;
            gpio_p2 <= gpio_p1;
        end
    end

    // Request payload only matters while a wait state is armed, so it carries no reset
    always_ff @(posedge CLK) begin
        if (req_valid) begin
            seg_lat  <= REQ_SEGMENT;
            time_lat <= REQ_VALUE;
            rep_lat  <= REQ_REP;
            gsel_lat <= GSEL_W'(REQ_VALUE % 64'(GPIO_NUM));
        end
    end

    always_comb begin
        switch_now = 1'b0;
        case (state)
            WAIT_IDX:  switch_now = IDX_VALID && (STOP || (IDX == CYCLE));
            WAIT_TIME: switch_now = (SYS_TIME >= time_lat);
            WAIT_GPIO: switch_now = gpio_rise[gsel_lat];
            default:   switch_now = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            SEGMENT  <= 1'b0;
            REQ_ACK  <= 1'b0;
            REQ_ERR  <= 1'b0;
            SWITCHED <= 1'b0;
            BUSY     <= 1'b0;
            STOP     <= 1'b0;
            rep_cnt  <= REP_INF;
        end else begin
            REQ_ACK  <= req_valid;
            REQ_ERR  <= UPDATE_REQ && !req_valid;
            SWITCHED <= 1'b0;

            // Repeat accounting for the active segment; a switch below overrides it
            if (period_end && !STOP && (rep_cnt != REP_INF)) begin
                if (rep_cnt == 16'd0)
                    STOP <= 1'b1;
                else
                    rep_cnt <= rep_cnt - 16'd1;
            end

            if (req_valid) begin
                case (REQ_MODE)
                    MODE_IMM: begin
                        SEGMENT  <= REQ_SEGMENT;
                        SWITCHED <= 1'b1;
                        rep_cnt  <= REQ_REP;
                        STOP     <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= IDLE;
                    end
                    MODE_SYNC: begin
                        BUSY  <= 1'b1;
                        state <= WAIT_IDX;
                    end
                    MODE_TIME: begin
                        BUSY  <= 1'b1;
                        state <= WAIT_TIME;
                    end
                    MODE_GPIO: begin
                        BUSY  <= 1'b1;
                        state <= WAIT_GPIO;
                    end
                    default: state <= state;
                endcase
            end else if (switch_now) begin
                SEGMENT  <= seg_lat;
                SWITCHED <= 1'b1;
                rep_cnt  <= rep_lat;
                STOP     <= 1'b0;
                BUSY     <= 1'b0;
                state    <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_segment_transition.sv
// Directed bench for segment_transition: each task drives one scenario and checks
// outputs one time unit after the active clock edge.
module tb_segment_transition;

    logic        CLK;
    logic        RST;
    logic [63:0] SYS_TIME;
    logic        UPDATE_REQ;
    logic        REQ_SEGMENT;
    logic [2:0]  REQ_MODE;
    logic [63:0] REQ_VALUE;
    logic [15:0] REQ_REP;
    logic [3:0]  GPIO_IN;
    logic [12:0] IDX;
    logic [12:0] CYCLE;
    logic        IDX_VALID;
    logic        SEGMENT;
    logic        REQ_ACK;
    logic        REQ_ERR;
    logic        SWITCHED;
    logic        BUSY;
    logic        STOP;

    int errors = 0;
    int checks = 0;

    segment_transition #(.IDX_W(13), .GPIO_NUM(4)) dut (
        .CLK(CLK), .RST(RST), .SYS_TIME(SYS_TIME), .UPDATE_REQ(UPDATE_REQ),
        .REQ_SEGMENT(REQ_SEGMENT), .REQ_MODE(REQ_MODE), .REQ_VALUE(REQ_VALUE),
        .REQ_REP(REQ_REP), .GPIO_IN(GPIO_IN), .IDX(IDX), .CYCLE(CYCLE),
        .IDX_VALID(IDX_VALID), .SEGMENT(SEGMENT), .REQ_ACK(REQ_ACK),
        .REQ_ERR(REQ_ERR), .SWITCHED(SWITCHED), .BUSY(BUSY), .STOP(STOP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input logic seg, input logic [2:0] mode,
                          input logic [63:0] value, input logic [15:0] rep);
        UPDATE_REQ  = 1'b1;
        REQ_SEGMENT = seg;
        REQ_MODE    = mode;
        REQ_VALUE   = value;
        REQ_REP     = rep;
        tick();
        UPDATE_REQ  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({SEGMENT, REQ_ACK, REQ_ERR, SWITCHED, BUSY, STOP} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {SEGMENT, REQ_ACK, REQ_ERR, SWITCHED, BUSY, STOP});
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();
        checks++;
        if ({SEGMENT, BUSY, STOP} !== 3'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 000", {SEGMENT, BUSY, STOP});
        end
    endtask

    task automatic test_immediate();
        do_req(1'b1, 3'd0, 64'd0, 16'hFFFF);
        checks++;
        if ({REQ_ACK, SWITCHED, SEGMENT, BUSY} !== 4'b1110) begin
            errors++;
            $display("FAIL imm_cycle1 ack/sw/seg/busy: got %b want 1110",
                     {REQ_ACK, SWITCHED, SEGMENT, BUSY});
        end
        tick();
        checks++;
        if ({REQ_ACK, SWITCHED, SEGMENT, BUSY} !== 4'b0010) begin
            errors++;
            $display("FAIL imm_cycle2 ack/sw/seg/busy: got %b want 0010",
                     {REQ_ACK, SWITCHED, SEGMENT, BUSY});
        end
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 3'd0, 64'd0, 16'hFFFF);
        checks++;
        if ({SWITCHED, SEGMENT} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_first sw/seg: got %b want 10", {SWITCHED, SEGMENT});
        end
        do_req(1'b0, 3'd0, 64'd0, 16'hFFFF);
        checks++;
        if ({REQ_ACK, SWITCHED, SEGMENT} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_same_segment ack/sw/seg: got %b want 110",
                     {REQ_ACK, SWITCHED, SEGMENT});
        end
    endtask

    task automatic test_sys_time();
        SYS_TIME = 64'd990;
        do_req(1'b1, 3'd2, 64'd1000, 16'hFFFF);
        checks++;
        if ({REQ_ACK, BUSY, SEGMENT} !== 3'b110) begin
            errors++;
            $display("FAIL time_arm ack/busy/seg: got %b want 110", {REQ_ACK, BUSY, SEGMENT});
        end
        for (int t = 991; t <= 1000; t++) begin
            SYS_TIME = 64'(t);
            tick();
            checks++;
            if (SEGMENT !== ((t >= 1000) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL time_wait_seg t=%0d: got %b want %b", t, SEGMENT,
                         (t >= 1000) ? 1'b1 : 1'b0);
            end
        end
        checks++;
        if ({SWITCHED, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL time_switch sw/busy: got %b want 10", {SWITCHED, BUSY});
        end
        SYS_TIME = 64'd990;
        do_req(1'b0, 3'd2, 64'd5, 16'hFFFF);
        checks++;
        if ({BUSY, SEGMENT, SWITCHED} !== 3'b110) begin
            errors++;
            $display("FAIL past_time_lat1 busy/seg/sw: got %b want 110", {BUSY, SEGMENT, SWITCHED});
        end
        tick();
        checks++;
        if ({BUSY, SEGMENT, SWITCHED} !== 3'b001) begin
            errors++;
            $display("FAIL past_time_lat2 busy/seg/sw: got %b want 001", {BUSY, SEGMENT, SWITCHED});
        end
    endtask

    task automatic test_sync_idx();
        CYCLE = 13'd9;
        do_req(1'b1, 3'd1, 64'd0, 16'hFFFF);
        for (int i = 0; i <= 9; i++) begin
            IDX       = 13'(i);
            IDX_VALID = 1'b1;
            tick();
            checks++;
            if (SEGMENT !== ((i == 9) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL sync_idx_seg idx=%0d: got %b want %b", i, SEGMENT,
                         (i == 9) ? 1'b1 : 1'b0);
            end
        end
        IDX_VALID = 1'b0;
        checks++;
        if ({SWITCHED, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL sync_idx_switch sw/busy: got %b want 10", {SWITCHED, BUSY});
        end
    endtask

    task automatic test_repeat();
        logic seen_stop;
        CYCLE = 13'd3;
        do_req(1'b0, 3'd0, 64'd0, 16'd2);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i <= 3; i++) begin
                IDX       = 13'(i);
                IDX_VALID = 1'b1;
                tick();
            end
            checks++;
            if (STOP !== ((p >= 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL repeat_stop period=%0d: got %b want %b", p, STOP,
                         (p >= 2) ? 1'b1 : 1'b0);
            end
        end
        IDX_VALID = 1'b0;
        do_req(1'b1, 3'd1, 64'd0, 16'hFFFF);
        IDX       = 13'd0;
        IDX_VALID = 1'b1;
        tick();
        IDX_VALID = 1'b0;
        checks++;
        if ({SEGMENT, SWITCHED, STOP} !== 3'b110) begin
            errors++;
            $display("FAIL stop_sync_switch seg/sw/stop: got %b want 110", {SEGMENT, SWITCHED, STOP});
        end
        seen_stop = 1'b0;
        for (int p = 0; p < 100; p++) begin
            for (int i = 0; i <= 3; i++) begin
                IDX       = 13'(i);
                IDX_VALID = 1'b1;
                tick();
                if (STOP !== 1'b0) seen_stop = 1'b1;
            end
        end
        IDX_VALID = 1'b0;
        checks++;
        if (seen_stop !== 1'b0) begin
            errors++;
            $display("FAIL infinite_repeat_stop: got %b want 0", seen_stop);
        end
    endtask

    task automatic test_gpio();
        GPIO_IN = 4'b0000;
        do_req(1'b0, 3'd3, 64'd2, 16'hFFFF);
        GPIO_IN = 4'b0010;
        for (int k = 0; k < 3; k++) tick();
        GPIO_IN = 4'b0000;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if ({SEGMENT, BUSY} !== 2'b11) begin
            errors++;
            $display("FAIL gpio_wrong_pin seg/busy: got %b want 11", {SEGMENT, BUSY});
        end
        GPIO_IN = 4'b0100;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (SEGMENT !== ((e == 3) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL gpio_edge%0d seg: got %b want %b", e, SEGMENT,
                         (e == 3) ? 1'b0 : 1'b1);
            end
        end
        checks++;
        if ({SWITCHED, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL gpio_switch sw/busy: got %b want 10", {SWITCHED, BUSY});
        end
        GPIO_IN = 4'b0000;
    endtask

    task automatic test_priority();
        SYS_TIME = 64'd990;
        CYCLE    = 13'd3;
        do_req(1'b1, 3'd2, 64'd0, 16'hFFFF);
        do_req(1'b1, 3'd1, 64'd0, 16'hFFFF);
        checks++;
        if ({REQ_ACK, SWITCHED, SEGMENT, BUSY} !== 4'b1001) begin
            errors++;
            $display("FAIL priority_newest ack/sw/seg/busy: got %b want 1001",
                     {REQ_ACK, SWITCHED, SEGMENT, BUSY});
        end
        tick();
        checks++;
        if ({SWITCHED, SEGMENT, BUSY} !== 3'b001) begin
            errors++;
            $display("FAIL priority_old_dropped sw/seg/busy: got %b want 001",
                     {SWITCHED, SEGMENT, BUSY});
        end
        IDX       = 13'd3;
        IDX_VALID = 1'b1;
        tick();
        IDX_VALID = 1'b0;
        checks++;
        if ({SWITCHED, SEGMENT, BUSY} !== 3'b110) begin
            errors++;
            $display("FAIL priority_new_switch sw/seg/busy: got %b want 110",
                     {SWITCHED, SEGMENT, BUSY});
        end
    endtask

    task automatic test_invalid();
        do_req(1'b0, 3'd5, 64'd0, 16'hFFFF);
        checks++;
        if ({REQ_ERR, REQ_ACK, BUSY, SEGMENT, SWITCHED} !== 5'b10010) begin
            errors++;
            $display("FAIL invalid_idle err/ack/busy/seg/sw: got %b want 10010",
                     {REQ_ERR, REQ_ACK, BUSY, SEGMENT, SWITCHED});
        end
        do_req(1'b0, 3'd1, 64'd0, 16'hFFFF);
        do_req(1'b1, 3'd7, 64'd0, 16'hFFFF);
        checks++;
        if ({REQ_ERR, REQ_ACK, BUSY, SEGMENT} !== 4'b1011) begin
            errors++;
            $display("FAIL invalid_busy err/ack/busy/seg: got %b want 1011",
                     {REQ_ERR, REQ_ACK, BUSY, SEGMENT});
        end
        IDX       = 13'd3;
        IDX_VALID = 1'b1;
        tick();
        IDX_VALID = 1'b0;
        checks++;
        if ({SWITCHED, SEGMENT, BUSY, REQ_ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL invalid_pending_kept sw/seg/busy/err: got %b want 1000",
                     {SWITCHED, SEGMENT, BUSY, REQ_ERR});
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen_sw;
        do_req(1'b1, 3'd0, 64'd0, 16'hFFFF);
        SYS_TIME = 64'd990;
        do_req(1'b0, 3'd2, 64'd1000, 16'hFFFF);
        SYS_TIME = 64'd991;
        tick();
        SYS_TIME = 64'd992;
        tick();
        checks++;
        if ({SEGMENT, BUSY} !== 2'b11) begin
            errors++;
            $display("FAIL mid_wait_pre_reset seg/busy: got %b want 11", {SEGMENT, BUSY});
        end
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if ({SEGMENT, REQ_ACK, REQ_ERR, SWITCHED, BUSY, STOP} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b want 000000",
                     {SEGMENT, REQ_ACK, REQ_ERR, SWITCHED, BUSY, STOP});
        end
        tick();
        RST = 1'b0;
        seen_sw = 1'b0;
        for (int t = 993; t <= 1010; t++) begin
            SYS_TIME = 64'(t);
            tick();
            if (SWITCHED !== 1'b0 || BUSY !== 1'b0 || SEGMENT !== 1'b0) seen_sw = 1'b1;
        end
        checks++;
        if (seen_sw !== 1'b0) begin
            errors++;
            $display("FAIL reset_discards_pending: got activity=%b want 0", seen_sw);
        end
    endtask

    initial begin
        RST         = 1'b1;
        SYS_TIME    = 64'd0;
        UPDATE_REQ  = 1'b0;
        REQ_SEGMENT = 1'b0;
        REQ_MODE    = 3'd0;
        REQ_VALUE   = 64'd0;
        REQ_REP     = 16'hFFFF;
        GPIO_IN     = 4'b0000;
        IDX         = 13'd0;
        CYCLE       = 13'd0;
        IDX_VALID   = 1'b0;

        test_reset();
        test_immediate();
        test_back_to_back();
        test_sys_time();
        test_sync_idx();
        test_repeat();
        test_gpio();
        test_priority();
        test_invalid();
        test_reset_mid_wait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
